ha_array_acc_8x8: RTL
=====================

HA_ARRAY_ACC_8X8 -- requirements
Module: ha_array_acc_8x8

Interface
REQ-001 Parameter SAT_EN, default 1, meaning: 1 clamps an out-of-range sum to 16'hFFFF; 0 truncates to the low 16 bits.
REQ-002 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 Ports ha_array_k_t (k=0..3), input, 9 bits each: top-row half-adder-array bits; bit i has weight 2^(i+2k).
REQ-005 Ports ha_array_k_b (k=0..3), input, 7 bits each: bottom-row half-adder-array bits; bit i has weight 2^(i+2+2k).
REQ-006 Port in_valid, input, 1 bit: all eight ha_array buses are valid.
REQ-007 Port in_ready, output, 1 bit: the block can accept an operand set.
REQ-008 Port product, output, 16 bits: the reduced (approximate) product.
REQ-009 Port sat, output, 1 bit: the 17-bit sum exceeded 16'hFFFF.
REQ-010 Port out_valid, output, 1 bit: product and sat are valid.
REQ-011 Port out_ready, input, 1 bit: the downstream consumer accepts the result.

Function
REQ-012 The block SHALL implement a three-state FSM: IDLE, ACC, DONE.
REQ-013 in_ready SHALL equal 1 only in IDLE; out_valid SHALL equal 1 only in DONE.
REQ-014 In IDLE, on an edge with in_valid=1, the block SHALL latch all 64 ha_array bits, clear the 17-bit accumulator, set idx=0 and enter ACC.
REQ-015 In IDLE, on an edge with in_valid=0, the state SHALL be unchanged.
REQ-016 Row value SHALL be defined as row_k = sum(t[i]<<i) + sum(b[i]<<(i+2)); it is 10 bits wide, with a maximum of 1019.
REQ-017 Each ACC edge SHALL add (row_idx << 2*idx) to the accumulator, zero-extended to 17 bits, then increment idx.
REQ-018 On the ACC edge with idx=3, the block SHALL perform the last add and enter DONE.
REQ-019 On entry to DONE, the block SHALL register product and sat from the final accumulator value.
REQ-020 Latency: with acceptance at edge E0, the adds SHALL occur at E1..E4, and out_valid SHALL be 1 after E4 (4 cycles).
REQ-021 With SAT_EN=1 and acc[16]=1: product=16'hFFFF and sat=1.
REQ-022 With SAT_EN=0: product=acc[15:0] and sat=acc[16].
REQ-023 In DONE, product and sat SHALL hold stable until an edge with out_ready=1.
REQ-024 On that edge (DONE with out_ready=1), the block SHALL return to IDLE; product and sat SHALL retain their value.
REQ-025 There SHALL be no overlap: the block SHALL NOT accept a new operand set in ACC or DONE. in_valid is ignored there, and the latched operands SHALL be unaffected by input changes.
REQ-026 The latched operands SHALL be used for all adds; live input values SHALL NOT be used after acceptance.
REQ-027 idx SHALL be 2 bits and SHALL wrap only by the FSM leaving ACC; it SHALL NOT be reused after overflow.

Reset
REQ-028 rst=1 at an edge SHALL force IDLE, idx=0, acc=0, product=0, sat=0, out_valid=0, in_ready=1, from any state.
REQ-029 Reset SHALL override a simultaneous in_valid or out_ready; an operation in flight SHALL be discarded with no output.
REQ-030 The first edge with rst=0 SHALL behave as an IDLE edge.

Verification
REQ-031 Scenario (unit weight): only ha_array_0_t[0]=1, in_valid pulsed -> 4 cycles later out_valid=1, product=16'h0001, sat=0.
REQ-032 Scenario (top weight): only ha_array_3_b[6]=1 -> product=16'h4000 (weight 2^14), sat=0; only ha_array_2_t[8]=1 -> product=16'h1000.
REQ-033 Scenario (saturation): all t and b bits = 1, giving sum 1019*85 = 86615 -> SAT_EN=1: product=16'hFFFF, sat=1; SAT_EN=0: product=16'h5257, sat=1.
REQ-034 Scenario (backpressure): out_ready=0 for 10 cycles after out_valid -> product stable, in_ready=0, and new in_valid ignored; out_ready=1 -> IDLE the next cycle.
REQ-035 Scenario (mid-ACC reset): rst asserted at idx=2 -> next cycle in IDLE with product=0 and out_valid=0; a following operation completes correctly.
REQ-036 Scenario (input change after accept): the inputs change during ACC -> the result matches the latched operand set.

Source files
------------

// File: rtl/ha_array_acc_8x8.sv
// ha_array_acc_8x8: reduces a 4-row half-adder array to a 16-bit product over four accumulate cycles
module ha_array_acc_8x8 #(
    parameter int SAT_EN = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [8:0]  ha_array_0_t,
    input  logic [8:0]  ha_array_1_t,
    input  logic [8:0]  ha_array_2_t,
    input  logic [8:0]  ha_array_3_t,
    input  logic [6:0]  ha_array_0_b,
    input  logic [6:0]  ha_array_1_b,
    input  logic [6:0]  ha_array_2_b,
    input  logic [6:0]  ha_array_3_b,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] product,
    output logic        sat,
    output logic        out_valid,
    input  logic        out_ready
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACC  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  r_idx;
    logic [16:0] r_acc;
    logic [8:0]  r_t [4];
    logic [6:0]  r_b [4];
    logic [15:0] r_product;
    logic        r_sat;
    logic [9:0]  w_row;
    logic [16:0] w_add;
    logic [16:0] w_sum;

    assign in_ready  = r_state == S_IDLE;
    assign out_valid = r_state == S_DONE;
    assign product   = r_product;
    assign sat       = r_sat;

    // Row value of the current row, shifted to its 2^(2*idx) weight and added to the running sum
    always_comb begin
        w_row = 10'(r_t[r_idx]) + {1'b0, r_b[r_idx], 2'b00};
        w_add = 17'(w_row) << {r_idx, 1'b0};
        w_sum = r_acc + w_add;
    end

    // Operand capture only on acceptance, so later input changes never reach the adds
    always_ff @(posedge clk) begin
        if (in_ready && in_valid) begin
            r_t[0] <= ha_array_0_t;
            r_t[1] <= ha_array_1_t;
            r_t[2] <= ha_array_2_t;
            r_t[3] <= ha_array_3_t;
            r_b[0] <= ha_array_0_b;
            r_b[1] <= ha_array_1_b;
            r_b[2] <= ha_array_2_b;
            r_b[3] <= ha_array_3_b;
        end
    end

    // IDLE -> ACC (four adds) -> DONE handshake; result registered from the final sum
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_idx     <= 2'd0;
            r_acc     <= 17'd0;
            r_product <= 16'd0;
            r_sat     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_acc   <= 17'd0;
                        r_idx   <= 2'd0;
                        r_state <= S_ACC;
                    end
                end
                S_ACC: begin
                    r_acc <= w_sum;
                    r_idx <= r_idx + 2'd1;
                    if (r_idx == 2'd3) begin
                        r_state   <= S_DONE;
                        r_product <= (SAT_EN != 0 && w_sum[16]) ? 16'hFFFF : w_sum[15:0];
                        r_sat     <= w_sum[16];
                    end
                end
                S_DONE: begin
                    if (out_ready) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
